tex_rsp_serializer: RTL and testbench
=====================================

Name: tex_rsp_serializer

Overview:
- Sits directly downstream of the texture unit's response interface (valid/texels/tag/ready).
- Takes one full-width response of NUM_LANES 32-bit texels plus tag and emits it as NUM_BEATS = NUM_LANES/OUT_LANES narrower beats toward a writeback port narrower than the texture unit.
- Holds one response in a register and sequences beats with a counter.
- Supports back-to-back responses without bubbles.

Parameters:
NUM_LANES, 4, texels per input response; must be a multiple of OUT_LANES.
OUT_LANES, 1, texels per output beat; must be at least 1.
TAG_WIDTH, 1, response tag width; passed through unchanged.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
rsp_in_valid  input  1  input response valid
rsp_in_texels  input  NUM_LANES*32  lane i in bits [32i+31:32i]
rsp_in_tag  input  TAG_WIDTH  input tag
rsp_in_ready  output  1  block can accept input this cycle
rsp_out_valid  output  1  output beat valid
rsp_out_texels  output  OUT_LANES*32  lanes [beat*OUT_LANES +: OUT_LANES] of held response
rsp_out_tag  output  TAG_WIDTH  tag of held response, constant across its beats
rsp_out_beat  output  max(1,clog2(NUM_BEATS))  current beat index
rsp_out_last  output  1  high when rsp_out_beat == NUM_BEATS-1

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; beat counter=0; held texels and tag cleared to 0.
  - rsp_out_valid=0, rsp_out_beat=0, rsp_out_texels=0, rsp_out_tag=0.
  - rsp_in_ready=0 while reset is high.
- States:
  - IDLE: rsp_out_valid=0, rsp_in_ready=1. On in_valid&in_ready: latch texels and tag, beat=0, go to SEND.
  - SEND: rsp_out_valid=1. Output fire = out_valid&out_ready.
  - On fire with beat<NUM_BEATS-1: beat+1, stay in SEND.
  - On fire with beat==NUM_BEATS-1 (last):
    - If rsp_in_valid, latch the new response, beat=0, stay in SEND.
    - Otherwise go to IDLE, beat=0.
- rsp_in_ready = (state==IDLE) | (state==SEND & rsp_out_ready & rsp_out_last). This is a combinational out_ready→in_ready path and is intended.
- No fire: the held data, tag, beat and valid remain stable. This is AXI-style: once rsp_out_valid is asserted it stays asserted until fire.
- Latency: input accepted in cycle N produces beat 0 in cycle N+1. A response occupies exactly NUM_BEATS output cycles at full out_ready.
- Throughput: with in_valid and out_ready held high, output valid is continuous with no idle cycle between responses.
- rsp_out_last is combinational from the beat counter. rsp_out_texels is a mux of the held register indexed by the beat counter.
- NUM_BEATS==1: the block is a single-entry registered stage. rsp_out_beat is constant 0 and rsp_out_last is constant 1.
- Input data is sampled only on input fire. Changes on rsp_in_* while rsp_in_ready=0 have no effect.
- Reset mid-burst: the in-flight response is discarded. No partial beats appear after reset release.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1 → out_valid=0, in_ready=0, beat=0 throughout. First cycle after release: in_ready=1.
- NUM_LANES=4, OUT_LANES=1, out_ready=1; send texels {0x33,0x22,0x11,0x00} (lane3..0), tag=1, in cycle 0:
  - Cycles 1-4: texels 0x00,0x11,0x22,0x33 with beat 0..3 and tag=1.
  - last=1 only in cycle 4.
  - Cycle 5: out_valid=0.
- Back-to-back: responses A (tag 0) and B (tag 1) offered continuously → 8 consecutive valid beats. in_ready pulses high on A's last beat and B is latched there. No bubble between A beat3 and B beat0.
- Backpressure: drop out_ready in cycles 2-3 of a burst → beat 1 (0x11) is held stable for 3 cycles. in_ready=0 throughout. The burst completes at cycle 6.
- Reset mid-burst: assert reset asynchronously after beat 1 → out_valid drops immediately. After release out_valid=0 and the next accepted response starts at beat 0.
- NUM_LANES=4, OUT_LANES=2: input {0xD,0xC,0xB,0xA} → beat0 = {0xB,0xA}, beat1 = {0xD,0xC}, last on beat1. A separate NUM_LANES=OUT_LANES=2 build passes data through with 1-cycle latency and last=1.

Source files
------------

// File: rtl/tex_rsp_serializer.sv
// tex_rsp_serializer
// Holds one full-width texture response (NUM_LANES texels + tag) and replays
// it as NUM_BEATS narrower beats of OUT_LANES texels each. A new response can
// be accepted on the cycle the last beat leaves, so back-to-back responses
// stream without idle cycles.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. Once rsp_out_valid rises it stays high, and texels, tag
// and beat stay constant, until the beat is taken. rsp_in_ready is
// combinational from rsp_out_ready on the last beat. This lets the next
// response be loaded in the same cycle the current one finishes.
module tex_rsp_serializer #(
    parameter int NUM_LANES = 4,
    parameter int OUT_LANES = 1,
    parameter int TAG_WIDTH = 1,
    localparam int NUM_BEATS = NUM_LANES / OUT_LANES,
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rsp_in_valid,
    input  logic [NUM_LANES*32-1:0]  rsp_in_texels,
    input  logic [TAG_WIDTH-1:0]     rsp_in_tag,
    output logic                     rsp_in_ready,
    output logic                     rsp_out_valid,
    input  logic                     rsp_out_ready,
    output logic [OUT_LANES*32-1:0]  rsp_out_texels,
    output logic [TAG_WIDTH-1:0]     rsp_out_tag,
    output logic [BEAT_W-1:0]        rsp_out_beat,
    output logic                     rsp_out_last,
    output logic                     dbg_state_o
);

    localparam int IN_W  = NUM_LANES * 32;
    localparam int OUT_W = OUT_LANES * 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [IN_W-1:0]        texels_q, texels_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;

    logic                   out_last;
    logic                   out_fire;
    logic                   in_fire;

    // Last beat of the held response; always true for a single-beat build.
    assign out_last = (beat_q == BEAT_W'(NUM_BEATS - 1));

    assign rsp_out_valid = (state_q == SEND);
    assign out_fire      = rsp_out_valid & rsp_out_ready;

    // Ready when empty, or when the last beat is leaving this cycle.
    // Forced low during reset so nothing is taken while the block is cleared.
    assign rsp_in_ready = ~reset &
                          ((state_q == IDLE) |
                           ((state_q == SEND) & rsp_out_ready & out_last));
    assign in_fire      = rsp_in_valid & rsp_in_ready;

    assign rsp_out_tag  = tag_q;
    assign rsp_out_beat = beat_q;
    assign rsp_out_last = out_last;
    assign dbg_state_o  = state_q;

    // Output lane mux: select the OUT_LANES texels addressed by the beat counter.
    always_comb begin
        rsp_out_texels = '0;
        for (int b = 0; b < NUM_BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                rsp_out_texels = texels_q[b*OUT_W +: OUT_W];
            end
        end
    end

    // Next-state: load on input transfer, advance beat on output transfer.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        texels_d = texels_q;
        tag_d    = tag_q;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d  = SEND;
                    beat_d   = '0;
                    texels_d = rsp_in_texels;
                    tag_d    = rsp_in_tag;
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (!out_last) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end else if (in_fire) begin
                        // Chain straight into the next response, no bubble.
                        beat_d   = '0;
                        texels_d = rsp_in_texels;
                        tag_d    = rsp_in_tag;
                    end else begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State registers; reset discards any in-flight response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            texels_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            texels_q <= texels_d;
            tag_q    <= tag_d;
        end
    end

endmodule

// File: tb/tb_tex_rsp_serializer.sv
// Bench for tex_rsp_serializer: main 4->1 build with a beat scoreboard, plus
// a 4->2 build and a 2->2 (single-beat) build checked directly.
module tb_tex_rsp_serializer;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- main DUT: 4 lanes -> 1 lane ----------------
    logic         in_valid = 1'b0;
    logic [127:0] in_tex   = '0;
    logic [0:0]   in_tag   = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_tex;
    logic [0:0]   out_tag;
    logic [1:0]   out_beat;
    logic         out_last;
    logic         dbg_a;

    tex_rsp_serializer #(.NUM_LANES(4), .OUT_LANES(1), .TAG_WIDTH(1)) dut_a (
        .clk(clk), .reset(reset),
        .rsp_in_valid(in_valid), .rsp_in_texels(in_tex), .rsp_in_tag(in_tag),
        .rsp_in_ready(in_ready),
        .rsp_out_valid(out_valid), .rsp_out_ready(out_ready),
        .rsp_out_texels(out_tex), .rsp_out_tag(out_tag),
        .rsp_out_beat(out_beat), .rsp_out_last(out_last),
        .dbg_state_o(dbg_a)
    );

    // ---------------- DUT b: 4 lanes -> 2 lanes ----------------
    logic         b_in_valid = 1'b0;
    logic [127:0] b_in_tex   = '0;
    logic [3:0]   b_in_tag   = '0;
    logic         b_in_ready;
    logic         b_out_valid;
    logic [63:0]  b_out_tex;
    logic [3:0]   b_out_tag;
    logic [0:0]   b_out_beat;
    logic         b_out_last;
    logic         dbg_b;

    tex_rsp_serializer #(.NUM_LANES(4), .OUT_LANES(2), .TAG_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset),
        .rsp_in_valid(b_in_valid), .rsp_in_texels(b_in_tex), .rsp_in_tag(b_in_tag),
        .rsp_in_ready(b_in_ready),
        .rsp_out_valid(b_out_valid), .rsp_out_ready(1'b1),
        .rsp_out_texels(b_out_tex), .rsp_out_tag(b_out_tag),
        .rsp_out_beat(b_out_beat), .rsp_out_last(b_out_last),
        .dbg_state_o(dbg_b)
    );

    // ---------------- DUT c: 2 lanes -> 2 lanes (single beat) ----------------
    logic         c_in_valid = 1'b0;
    logic [63:0]  c_in_tex   = '0;
    logic [3:0]   c_in_tag   = '0;
    logic         c_in_ready;
    logic         c_out_valid;
    logic [63:0]  c_out_tex;
    logic [3:0]   c_out_tag;
    logic [0:0]   c_out_beat;
    logic         c_out_last;
    logic         dbg_c;

    tex_rsp_serializer #(.NUM_LANES(2), .OUT_LANES(2), .TAG_WIDTH(4)) dut_c (
        .clk(clk), .reset(reset),
        .rsp_in_valid(c_in_valid), .rsp_in_texels(c_in_tex), .rsp_in_tag(c_in_tag),
        .rsp_in_ready(c_in_ready),
        .rsp_out_valid(c_out_valid), .rsp_out_ready(1'b1),
        .rsp_out_texels(c_out_tex), .rsp_out_tag(c_out_tag),
        .rsp_out_beat(c_out_beat), .rsp_out_last(c_out_last),
        .dbg_state_o(dbg_c)
    );

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- driver helpers ----------------
    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // ---------------- scoreboard for main DUT ----------------
    // Entry: {tag, beat, last, texel}
    localparam int EXP_W = 36;
    logic [EXP_W-1:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_tex;
    logic [0:0]  prev_tag;
    logic [1:0]  prev_beat;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_tex",   64'(out_tex),   64'(prev_tex));
                check("stall_tag",   64'(out_tag),   64'(prev_tag));
                check("stall_beat",  64'(out_beat),  64'(prev_beat));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(out_tex), 64'hdead_0000);
                end else begin
                    logic [EXP_W-1:0] e;
                    e = exp_q.pop_front();
                    check("out_tex",  64'(out_tex),  64'(e[31:0]));
                    check("out_last", 64'(out_last), 64'(e[32]));
                    check("out_beat", 64'(out_beat), 64'(e[34:33]));
                    check("out_tag",  64'(out_tag),  64'(e[35]));
                end
            end
            if (in_valid && in_ready) begin
                for (int b = 0; b < 4; b++) begin
                    exp_q.push_back({in_tag, 2'(b), (b == 3), in_tex[b*32 +: 32]});
                end
            end
            prev_stall = out_valid & ~out_ready;
            prev_tex   = out_tex;
            prev_tag   = out_tag;
            prev_beat  = out_beat;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    localparam logic [127:0] TEX_BASIC = {32'h33, 32'h22, 32'h11, 32'h00};
    localparam logic [127:0] TEX_A     = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] TEX_B     = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    localparam logic [127:0] TEX_E     = {32'hE3, 32'hE2, 32'hE1, 32'hE0};

    initial begin
        // Reset held 3 cycles with input valid asserted.
        in_valid = 1'b1;
        in_tex   = TEX_A;
        in_tag   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready",  64'(in_ready),  64'd0);
            check("rst_beat",      64'(out_beat),  64'd0);
        end
        check("rst_tex",   64'(out_tex), 64'd0);
        check("rst_tag",   64'(out_tag), 64'd0);
        check("rst_state", 64'(dbg_a),   64'd0);
        cyc();
        reset    = 1'b0;
        in_valid = 1'b0;
        sample();
        check("post_rst_in_ready",  64'(in_ready),  64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Single response at full out_ready.
        cyc();
        in_valid  = 1'b1;
        in_tex    = TEX_BASIC;
        in_tag    = 1'b1;
        out_ready = 1'b1;
        sample();
        check("basic_in_ready", 64'(in_ready), 64'd1);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            in_valid = 1'b0;
            sample();
            if (c <= 4) begin
                check("basic_valid", 64'(out_valid), 64'd1);
                check("basic_beat",  64'(out_beat),  64'(c - 1));
                check("basic_last",  64'(out_last),  64'(c == 4));
            end else begin
                check("basic_idle", 64'(out_valid), 64'd0);
            end
        end

        // Back-to-back: A then B offered continuously.
        cyc();
        in_valid = 1'b1;
        in_tex   = TEX_A;
        in_tag   = 1'b0;
        sample();
        for (int c = 1; c <= 9; c++) begin
            cyc();
            if (c == 1) begin
                in_tex = TEX_B;
                in_tag = 1'b1;
            end
            if (c == 5) in_valid = 1'b0;
            sample();
            if (c <= 8) begin
                check("b2b_valid",    64'(out_valid), 64'd1);
                check("b2b_in_ready", 64'(in_ready),  64'(c == 4 || c == 8));
            end else begin
                check("b2b_idle", 64'(out_valid), 64'd0);
            end
        end

        // Backpressure: out_ready low in cycles 2-3.
        cyc();
        in_valid = 1'b1;
        in_tex   = TEX_BASIC;
        in_tag   = 1'b0;
        sample();
        for (int c = 1; c <= 7; c++) begin
            cyc();
            in_valid  = 1'b0;
            out_ready = !(c == 2 || c == 3);
            sample();
            if (c <= 6) begin
                check("bp_valid",    64'(out_valid), 64'd1);
                check("bp_in_ready", 64'(in_ready),  64'(c == 6));
                if (c >= 2 && c <= 4) begin
                    check("bp_hold_beat", 64'(out_beat), 64'd1);
                    check("bp_hold_tex",  64'(out_tex),  64'h11);
                end
            end else begin
                check("bp_idle", 64'(out_valid), 64'd0);
            end
        end

        // Reset mid-burst after beat 1.
        cyc();
        in_valid = 1'b1;
        in_tex   = TEX_A;
        sample();
        cyc();
        in_valid = 1'b0;
        sample();
        cyc();
        sample();
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_valid",    64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready),  64'd0);
        sample();
        cyc();
        reset = 1'b0;
        sample();
        check("midrst_rel_valid", 64'(out_valid), 64'd0);
        check("midrst_rel_beat",  64'(out_beat),  64'd0);
        cyc();
        in_valid = 1'b1;
        in_tex   = TEX_E;
        in_tag   = 1'b1;
        sample();
        cyc();
        in_valid = 1'b0;
        sample();
        check("midrst_new_beat", 64'(out_beat), 64'd0);
        check("midrst_new_tex",  64'(out_tex),  64'hE0);
        for (int c = 0; c < 4; c++) begin
            cyc();
            sample();
        end

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            cyc();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_tex    = {$urandom, $urandom, $urandom, $urandom};
            in_tag    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            sample();
        end
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sample();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            cyc();
            sample();
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        cyc();
        sample();
        check("drain_idle", 64'(out_valid), 64'd0);

        // 4 -> 2 lanes.
        cyc();
        b_in_valid = 1'b1;
        b_in_tex   = {32'hD, 32'hC, 32'hB, 32'hA};
        b_in_tag   = 4'h9;
        sample();
        check("w2_in_ready", 64'(b_in_ready), 64'd1);
        cyc();
        b_in_valid = 1'b0;
        sample();
        check("w2_b0_valid", 64'(b_out_valid), 64'd1);
        check("w2_b0_tex",   b_out_tex, 64'h0000000B_0000000A);
        check("w2_b0_beat",  64'(b_out_beat), 64'd0);
        check("w2_b0_last",  64'(b_out_last), 64'd0);
        check("w2_b0_tag",   64'(b_out_tag),  64'h9);
        cyc();
        sample();
        check("w2_b1_tex",  b_out_tex, 64'h0000000D_0000000C);
        check("w2_b1_beat", 64'(b_out_beat), 64'd1);
        check("w2_b1_last", 64'(b_out_last), 64'd1);
        check("w2_b1_tag",  64'(b_out_tag),  64'h9);
        cyc();
        sample();
        check("w2_idle", 64'(b_out_valid), 64'd0);

        // 2 -> 2 lanes: single registered stage.
        cyc();
        c_in_valid = 1'b1;
        c_in_tex   = {32'h55, 32'h44};
        c_in_tag   = 4'h3;
        sample();
        cyc();
        c_in_valid = 1'b0;
        sample();
        check("w1_valid",    64'(c_out_valid), 64'd1);
        check("w1_tex",      c_out_tex, 64'h00000055_00000044);
        check("w1_beat",     64'(c_out_beat), 64'd0);
        check("w1_last",     64'(c_out_last), 64'd1);
        check("w1_tag",      64'(c_out_tag),  64'h3);
        check("w1_in_ready", 64'(c_in_ready), 64'd1);
        cyc();
        sample();
        check("w1_idle", 64'(c_out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
